// File: rtl/axis_packet_arbiter.sv
// Round-robin, packet-granular merge of NUM_INPUTS AXI-Stream sources onto one master stream.
// One idle arbitration cycle between packets; zero-latency combinational data path while a packet is locked.
module axis_packet_arbiter #(
  parameter int TDATA_WIDTH = 32,
  parameter int NUM_INPUTS  = 2,
  parameter int GRANT_WIDTH = $clog2(NUM_INPUTS)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic [NUM_INPUTS*TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_INPUTS-1:0]             s_axis_tlast,
  input  logic [NUM_INPUTS-1:0]             s_axis_tvalid,
  output logic [NUM_INPUTS-1:0]             s_axis_tready,
  output logic [TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [GRANT_WIDTH-1:0]            grant_idx,
  output logic                              busy,
  output logic [31:0]                       pkt_count
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [GRANT_WIDTH-1:0] last_grant;
  logic                   arb_found;
  logic [GRANT_WIDTH-1:0] arb_idx;
  logic                   pkt_end;
  logic [TDATA_WIDTH-1:0] in_tdata [NUM_INPUTS];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_unpack
    assign in_tdata[i] = s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
  end

  // base + offset wrapped into 0..NUM_INPUTS-1; offset never exceeds NUM_INPUTS
  function automatic logic [GRANT_WIDTH-1:0] rr_index(input logic [GRANT_WIDTH-1:0] base,
                                                      input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= NUM_INPUTS) sum = sum - NUM_INPUTS;
    return sum[GRANT_WIDTH-1:0];
  endfunction

  // Scan starts one past the previous winner, so the last served input ranks lowest.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= NUM_INPUTS; k++) begin
      if (!arb_found && s_axis_tvalid[rr_index(last_grant, k)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_index(last_grant, k);
      end
    end
  end

  always_comb begin
    m_axis_tdata  = in_tdata[grant_idx];
    m_axis_tlast  = busy & s_axis_tlast[grant_idx];
    m_axis_tvalid = busy & s_axis_tvalid[grant_idx];
    s_axis_tready = '0;
    if (busy) s_axis_tready[grant_idx] = m_axis_tready;
  end

  assign pkt_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      busy       <= 1'b0;
      grant_idx  <= '0;
      last_grant <= GRANT_WIDTH'(NUM_INPUTS - 1);
      pkt_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_found) begin
            state     <= BUSY;
            busy      <= 1'b1;
            grant_idx <= arb_idx;
          end
        end
        BUSY: begin
          if (pkt_end) begin
            state      <= IDLE;
            busy       <= 1'b0;
            last_grant <= grant_idx;
            pkt_count  <= pkt_count + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  a_single_ready: assert property (@(posedge clk) disable iff (!resetn) $onehot0(s_axis_tready));
`endif

endmodule
